divider_controller: RTL and testbench
=====================================

DIVIDER_CONTROLLER -- requirements
Module: divider_controller

Interface
REQ-001 The block SHALL have no parameters; the iteration count is fixed at 16 (16-bit operands).
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 start  input  1  bus request to divide the A/B values currently on the bus.
REQ-005 ack  input  1  bus acknowledge that clears done/error.
REQ-006 a_sign, b_sign  input  1 each  bit 15 of the bus operands A and B.
REQ-007 SB  input  1  datapath subtractor sign (1 = trial difference negative).
REQ-008 error_divided_0  input  1  datapath flag, divisor on the bus is zero.
REQ-009 dp_clr  output  1  synchronous clear to the datapath registers.
REQ-010 LdA, LdB  output  1 each  load dividend/divisor magnitudes.
REQ-011 LdTemp, LsftTemp, LsftA  output  1 each  remainder load, remainder shift and quotient shift.
REQ-012 busy  output  1  operation in progress (states CLR, LOAD, ITER).
REQ-013 done  output  1  result valid on datapath Q/R; held until ack.
REQ-014 error  output  1  divide-by-zero; held until ack.
REQ-015 q_neg, r_neg  output  1 each  sign-correction flags for the bus side.

Function
REQ-016 States SHALL be IDLE, CLR, LOAD, ITER, DONE and ERR, with a 4-bit iteration counter cnt.
REQ-017 IDLE: start=1 and error_divided_0=1 SHALL go to ERR; start=1 and error_divided_0=0 SHALL go to CLR; otherwise stay.
REQ-018 On accepting start, q_neg SHALL register a_sign XOR b_sign and r_neg SHALL register a_sign; both hold until the next accepted start.
REQ-019 CLR (1 cycle): dp_clr=1, all other datapath controls 0; next state LOAD.
REQ-020 LOAD (1 cycle): LdA=LdB=1, cnt set to 0; next state ITER.
REQ-021 ITER: LsftA=1, LdTemp=~SB and LsftTemp=SB, combinational from SB in the same cycle; exactly one of LdTemp/LsftTemp is high.
REQ-022 In ITER, cnt SHALL increment each cycle; at cnt=15 the next state SHALL be DONE (exactly 16 ITER cycles), and cnt SHALL wrap to 0.
REQ-023 DONE: done=1 with no datapath controls active, so Q/R stay stable; ack=1 SHALL go to IDLE.
REQ-024 ERR: error=1 with no datapath loads or shifts; ack=1 SHALL go to IDLE.
REQ-025 Latency: with start accepted at edge N, done SHALL first be visible after edge N+18.
REQ-026 start SHALL be ignored whenever state is not IDLE.
REQ-027 ack SHALL be ignored outside DONE/ERR.
REQ-028 ack and start high in the same DONE/ERR cycle SHALL return to IDLE only; start must be re-presented.
REQ-029 busy, done and error SHALL be mutually exclusive.
REQ-030 Unreachable state encodings SHALL go to IDLE on the next edge.

Reset
REQ-031 reset=0 SHALL immediately force state to IDLE, independent of clk.
REQ-032 reset=0 SHALL force all outputs and cnt to 0, including q_neg and r_neg.
REQ-033 reset asserted mid-ITER SHALL abort the operation; no done/error SHALL follow release.
REQ-034 After reset release, the first accepted start SHALL behave as a fresh operation.

Verification
REQ-035 A=100, B=7, start pulse -> 1 dp_clr cycle, 1 LdA/LdB cycle, 16 LsftA cycles, then done after edge N+18 -> Q=14, R=2, q_neg=0.
REQ-036 A=-100, B=7 -> q_neg=1, r_neg=1, magnitudes Q=14, R=2; done held 5 cycles without ack, then cleared 1 cycle after ack.
REQ-037 B=0, start -> error=1 next cycle, no LdA/LdB/LsftA ever high, busy=0; ack -> IDLE.
REQ-038 start toggled during ITER and ack pulsed during ITER -> no effect; done still after edge N+18.
REQ-039 reset=0 at ITER cnt=7 -> all outputs 0 without a clock edge; after release, idle until the next start.
REQ-040 A=0xFFFF magnitude path, B=1 -> LdTemp never asserted incorrectly; Q=0xFFFF... (abs) with R=0; ack+start together in DONE -> IDLE, no new operation.

Source files
------------

// File: rtl/divider_controller.sv
`default_nettype none
// ============================================================================
//  Module      : divider_controller
//  Description : Sequencer for a 16-iteration restoring divider datapath.
//                Clears and loads the datapath, steps 16 shift/subtract
//                iterations steered by the subtractor sign, then holds the
//                result (or a divide-by-zero error) until acknowledged.
//  Revision    : 1.0 - initial release
// ============================================================================
module divider_controller (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic ack,
  input  logic a_sign,
  input  logic b_sign,
  input  logic SB,
  input  logic error_divided_0,
  output logic dp_clr,
  output logic LdA,
  output logic LdB,
  output logic LdTemp,
  output logic LsftTemp,
  output logic LsftA,
  output logic busy,
  output logic done,
  output logic error,
  output logic q_neg,
  output logic r_neg
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLR  = 3'd1,
    S_LOAD = 3'd2,
    S_ITER = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  localparam logic [3:0] C_LAST_ITER = 4'd15;

  state_t     r_state;
  logic [3:0] r_cnt;
  logic       r_dp_clr;
  logic       r_ld_a;
  logic       r_ld_b;
  logic       r_lsft_a;
  logic       r_busy;
  logic       r_done;
  logic       r_error;
  logic       r_q_neg;
  logic       r_r_neg;

  // State sequencing; every output is registered from the state being entered
  // so it is valid for the whole cycle spent in that state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_dp_clr <= 1'b0;
      r_ld_a   <= 1'b0;
      r_ld_b   <= 1'b0;
      r_lsft_a <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
      r_q_neg  <= 1'b0;
      r_r_neg  <= 1'b0;
    end else begin
      r_dp_clr <= 1'b0;
      r_ld_a   <= 1'b0;
      r_ld_b   <= 1'b0;
      r_lsft_a <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            // Sign flags are captured once per accepted request and held.
            r_q_neg <= a_sign ^ b_sign;
            r_r_neg <= a_sign;
            if (error_divided_0) begin
              r_state <= S_ERR;
              r_error <= 1'b1;
            end else begin
              r_state  <= S_CLR;
              r_dp_clr <= 1'b1;
              r_busy   <= 1'b1;
            end
          end
        end
        S_CLR: begin
          r_state <= S_LOAD;
          r_ld_a  <= 1'b1;
          r_ld_b  <= 1'b1;
          r_busy  <= 1'b1;
        end
        S_LOAD: begin
          r_state  <= S_ITER;
          r_cnt    <= 4'd0;
          r_lsft_a <= 1'b1;
          r_busy   <= 1'b1;
        end
        S_ITER: begin
          // 4-bit counter wraps to zero on the last iteration by itself.
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == C_LAST_ITER) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_lsft_a <= 1'b1;
            r_busy   <= 1'b1;
          end
        end
        S_DONE: begin
          if (ack) begin
            r_state <= S_IDLE;
          end else begin
            r_done <= 1'b1;
          end
        end
        S_ERR: begin
          if (ack) begin
            r_state <= S_IDLE;
          end else begin
            r_error <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // The remainder path follows the live subtractor sign; r_lsft_a is high
  // exactly in ITER, so it gates both controls to one-hot during iterations.
  assign LdTemp   = r_lsft_a & ~SB;
  assign LsftTemp = r_lsft_a &  SB;

  assign dp_clr = r_dp_clr;
  assign LdA    = r_ld_a;
  assign LdB    = r_ld_b;
  assign LsftA  = r_lsft_a;
  assign busy   = r_busy;
  assign done   = r_done;
  assign error  = r_error;
  assign q_neg  = r_q_neg;
  assign r_neg  = r_r_neg;

endmodule
`default_nettype wire

// File: tb/tb_divider_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_divider_controller
//  Description : Directed self-checking bench for divider_controller with a
//                small restoring-divider datapath wrapped around it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_divider_controller;

  logic clk = 1'b0;
  logic reset, start, ack, a_sign, b_sign;
  logic [15:0] a_mag, b_mag;
  logic w_sb, w_div0;
  logic dp_clr, LdA, LdB, LdTemp, LsftTemp, LsftA, busy, done, error, q_neg, r_neg;

  int checks = 0;
  int errors = 0;
  int excl_viol = 0;
  int temp_viol = 0;

  always #5 clk = ~clk;

  divider_controller dut (
    .clk(clk), .reset(reset), .start(start), .ack(ack),
    .a_sign(a_sign), .b_sign(b_sign), .SB(w_sb), .error_divided_0(w_div0),
    .dp_clr(dp_clr), .LdA(LdA), .LdB(LdB), .LdTemp(LdTemp), .LsftTemp(LsftTemp),
    .LsftA(LsftA), .busy(busy), .done(done), .error(error),
    .q_neg(q_neg), .r_neg(r_neg)
  );

  // Restoring-divider datapath: dq holds dividend then quotient, dt remainder.
  logic [15:0] dq, db, dt;
  logic [17:0] w_trial;
  assign w_trial = {1'b0, dt, dq[15]} - {2'b00, db};
  assign w_sb    = w_trial[17];
  assign w_div0  = (b_mag == 16'd0);

  always @(posedge clk) begin
    if (dp_clr) begin
      dq <= 16'd0; db <= 16'd0; dt <= 16'd0;
    end else begin
      if (LdA)      dq <= a_mag;
      if (LdB)      db <= b_mag;
      if (LdTemp)   dt <= w_trial[15:0];
      if (LsftTemp) dt <= {dt[14:0], dq[15]};
      if (LsftA)    dq <= {dq[14:0], ~w_sb};
    end
  end

  // Invariants: busy/done/error exclusive; remainder controls one-hot in ITER.
  always @(negedge clk) begin
    if (reset) begin
      if ($countones({busy, done, error}) > 1) excl_viol++;
      if (LsftA) begin
        if (LdTemp === LsftTemp || LdTemp !== ~w_sb) temp_viol++;
      end else if (LdTemp || LsftTemp) begin
        temp_viol++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] all_outs();
    return {dp_clr, LdA, LdB, LdTemp, LsftTemp, LsftA, busy, done, error, q_neg, r_neg};
  endfunction

  // Issue one request and step until done (bounded); k counts edges after
  // the accepting edge. disturb toggles start and pulses ack during ITER.
  task automatic do_div(input logic [15:0] am, input logic [15:0] bm,
                        input logic as, input logic bs, input bit disturb,
                        output int lat, output int ncl, output int nld, output int nsh);
    int k;
    a_mag = am; b_mag = bm; a_sign = as; b_sign = bs;
    ncl = 0; nld = 0; nsh = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    k = 0;
    while (!done && k < 40) begin
      if (dp_clr) ncl++;
      if (LdA && LdB) nld++;
      if (LsftA) nsh++;
      if (disturb && k >= 3 && k <= 15) begin
        start = k[0];
        ack   = (k == 8);
      end else begin
        start = 1'b0;
        ack   = 1'b0;
      end
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0; ack = 1'b0;
    lat = k;
  endtask

  task automatic ack_pulse();
    @(negedge clk); ack = 1'b1;
    @(posedge clk); #1 ack = 1'b0;
  endtask

  initial begin
    int lat, ncl, nld, nsh, cnt;
    reset = 1'b0; start = 1'b0; ack = 1'b0;
    a_sign = 1'b0; b_sign = 1'b0; a_mag = 16'd0; b_mag = 16'd1;

    // Reset state, before and after clock edges.
    #2 check("reset_outs_t0", 32'(all_outs()), 32'd0);
    repeat (3) @(posedge clk);
    #1 check("reset_outs_clk", 32'(all_outs()), 32'd0);
    @(negedge clk); reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("idle_outs", 32'(all_outs()), 32'd0);

    // 100 / 7
    do_div(16'd100, 16'd7, 1'b0, 1'b0, 1'b0, lat, ncl, nld, nsh);
    check("p_latency", lat, 18);
    check("p_dp_clr_cycles", ncl, 1);
    check("p_load_cycles", nld, 1);
    check("p_shift_cycles", nsh, 16);
    check("p_quot", dq, 14);
    check("p_rem", dt, 2);
    check("p_q_neg", q_neg, 0);
    check("p_r_neg", r_neg, 0);
    check("p_busy_in_done", busy, 0);
    ack_pulse();
    check("p_done_cleared", done, 0);

    // -100 / 7, done held without ack
    do_div(16'd100, 16'd7, 1'b1, 1'b0, 1'b0, lat, ncl, nld, nsh);
    check("n_latency", lat, 18);
    check("n_quot", dq, 14);
    check("n_rem", dt, 2);
    check("n_q_neg", q_neg, 1);
    check("n_r_neg", r_neg, 1);
    cnt = 0;
    repeat (5) begin @(negedge clk); if (done) cnt++; end
    check("n_done_held", cnt, 5);
    check("n_quot_stable", dq, 14);
    ack_pulse();
    check("n_done_after_ack", done, 0);
    check("n_signs_hold", {q_neg, r_neg}, 2'b11);

    // Divide by zero
    a_mag = 16'd5; b_mag = 16'd0; a_sign = 1'b0; b_sign = 1'b1;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("z_error", error, 1);
    check("z_busy", busy, 0);
    check("z_done", done, 0);
    check("z_q_neg", q_neg, 1);
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (LdA || LdB || LsftA || dp_clr) cnt++;
    end
    check("z_no_dp_ctrl", cnt, 0);
    check("z_error_held", error, 1);
    ack_pulse();
    check("z_error_cleared", error, 0);
    check("z_busy_after", busy, 0);

    // start toggled and ack pulsed during ITER
    do_div(16'd100, 16'd7, 1'b0, 1'b0, 1'b1, lat, ncl, nld, nsh);
    check("d_latency", lat, 18);
    check("d_shift_cycles", nsh, 16);
    check("d_quot", dq, 14);
    check("d_rem", dt, 2);
    ack_pulse();

    // Reset asserted asynchronously at ITER cnt=7
    a_mag = 16'd100; b_mag = 16'd7; a_sign = 1'b1; b_sign = 1'b0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 check("r_in_iter", {busy, LsftA}, 2'b11);
    #1 reset = 1'b0;
    #1 check("r_async_outs", 32'(all_outs()), 32'd0);
    @(negedge clk); reset = 1'b1;
    cnt = 0;
    repeat (25) begin @(negedge clk); if (busy || done || error) cnt++; end
    check("r_no_resume", cnt, 0);

    // 0xFFFF / 1, then ack+start together in DONE
    do_div(16'hFFFF, 16'd1, 1'b0, 1'b0, 1'b0, lat, ncl, nld, nsh);
    check("f_latency", lat, 18);
    check("f_quot", dq, 16'hFFFF);
    check("f_rem", dt, 0);
    @(negedge clk); ack = 1'b1; start = 1'b1;
    @(posedge clk); #1 ack = 1'b0; start = 1'b0;
    check("f_done_cleared", done, 0);
    cnt = 0;
    repeat (5) begin @(negedge clk); if (busy || done || error) cnt++; end
    check("f_no_new_op", cnt, 0);

    check("excl_violations", excl_viol, 0);
    check("temp_violations", temp_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
